// File: rtl/ogsc_datapath.sv
// Datapath end of the ogsc control interface: three-operand add/subtract
// sequence driven by the controller's control word, with a valid/ready result port.
module ogsc_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e,
  input  logic         m,
  input  logic         s0,
  input  logic         s1,
  input  logic         s2,
  input  logic         done,
  input  logic [W-1:0] din,
  input  logic         result_ready,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         ovf,
  output logic         seq_err,
  output logic         overrun,
  output logic [1:0]   step
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GOT_A = 2'b01;
  localparam logic [1:0] GOT_B = 2'b10;
  localparam logic [1:0] GOT_C = 2'b11;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_A    = 3'd1;
  localparam logic [2:0] OP_B    = 3'd2;
  localparam logic [2:0] OP_C    = 3'd3;
  localparam logic [2:0] OP_F    = 3'd4;
  localparam logic [2:0] OP_ILL  = 3'd5;

  // Two's complement overflow of lhs +/- rhs given the wrapped result.
  function automatic logic signed_ovf(input logic [W-1:0] lhs, input logic [W-1:0] rhs,
                                      input logic [W-1:0] res, input logic is_add);
    logic same_sign;
    same_sign = (lhs[W-1] == rhs[W-1]);
    if (is_add) begin
      signed_ovf = same_sign && (res[W-1] != lhs[W-1]);
    end else begin
      signed_ovf = !same_sign && (res[W-1] != lhs[W-1]);
    end
  endfunction

  logic [W-1:0] op_a;
  logic [W-1:0] acc;
  logic [2:0]   op;
  logic [2:0]   cmd;
  logic [W-1:0] lhs;
  logic [W-1:0] sum;
  logic         ovf_now;
  logic         publish;

  // Decode the control word; flags above the lowest 0 are don't-care.
  always_comb begin
    op = OP_NONE;
    if (!e) begin
      op = OP_NONE;
    end else if (done && !(s0 && s1 && s2)) begin
      op = OP_ILL;
    end else if (!s0) begin
      op = OP_A;
    end else if (!s1) begin
      op = OP_B;
    end else if (!s2) begin
      op = OP_C;
    end else if (done) begin
      op = OP_F;
    end else begin
      op = OP_ILL;
    end
  end

  // Demote legal steps arriving in the wrong sequencer state to errors.
  always_comb begin
    cmd = op;
    case (op)
      OP_B:    cmd = (step == GOT_A) ? OP_B : OP_ILL;
      OP_C:    cmd = (step == GOT_B) ? OP_C : OP_ILL;
      OP_F:    cmd = (step == GOT_C) ? OP_F : OP_ILL;
      default: cmd = op;
    endcase
  end

  // Shared adder/subtractor: B works from A, C from the accumulator.
  always_comb begin
    lhs     = (cmd == OP_B) ? op_a : acc;
    sum     = m ? (lhs + din) : (lhs - din);
    ovf_now = signed_ovf(lhs, din, sum, m);
    publish = (cmd == OP_F) && (!result_valid || result_ready);
  end

  // Sequencer, accumulator and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a         <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      seq_err      <= 1'b0;
      overrun      <= 1'b0;
      step         <= IDLE;
    end else begin
      case (cmd)
        OP_A: begin
          op_a    <= din;
          acc     <= din;
          ovf     <= 1'b0;
          seq_err <= 1'b0;
          step    <= GOT_A;
        end
        OP_B: begin
          acc  <= sum;
          ovf  <= ovf | ovf_now;
          step <= GOT_B;
        end
        OP_C: begin
          acc  <= sum;
          ovf  <= ovf | ovf_now;
          step <= GOT_C;
        end
        OP_F: begin
          step <= IDLE;
          if (!publish) begin
            overrun <= 1'b1;
          end
        end
        OP_ILL:  seq_err <= 1'b1;
        default: ;
      endcase
      // The consumer handshake runs regardless of e so an accepted result is never re-presented.
      if (publish) begin
        result       <= acc;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ogsc_datapath.sv
// Randomized and directed bench for ogsc_datapath against a step-level
// integer model of the add/subtract sequence and result handshake.
module tb_ogsc_datapath;

  localparam int W = 8;
  localparam int K_A = 0, K_B = 1, K_C = 2, K_F = 3, K_ILL1 = 4, K_ILL2 = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         e, m, s0, s1, s2, done;
  logic [W-1:0] din;
  logic         result_ready;
  logic [W-1:0] result;
  logic         result_valid, ovf, seq_err, overrun;
  logic [1:0]   step;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: stage counts completed steps of the current operation (0 = idle).
  int md_a, md_acc, md_res, md_stage;
  bit md_valid, md_ovf, md_err, md_ovr;

  ogsc_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .e(e), .m(m), .s0(s0), .s1(s1), .s2(s2), .done(done),
    .din(din), .result_ready(result_ready), .result(result),
    .result_valid(result_valid), .ovf(ovf), .seq_err(seq_err), .overrun(overrun),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int wrap8(input int t);
    int u;
    u = ((t % 256) + 256) % 256;
    return (u >= 128) ? u - 256 : u;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] rb;
    rb = md_res[7:0];
    check({tag, ".step"},    {30'd0, step},         md_stage);
    check({tag, ".result"},  {24'd0, result},       {24'd0, rb});
    check({tag, ".valid"},   {31'd0, result_valid}, {31'd0, md_valid});
    check({tag, ".ovf"},     {31'd0, ovf},          {31'd0, md_ovf});
    check({tag, ".seq_err"}, {31'd0, seq_err},      {31'd0, md_err});
    check({tag, ".overrun"}, {31'd0, overrun},      {31'd0, md_ovr});
  endtask

  task automatic model_reset();
    md_a = 0; md_acc = 0; md_res = 0; md_stage = 0;
    md_valid = 0; md_ovf = 0; md_err = 0; md_ovr = 0;
  endtask

  // One clock: drive the control word for an intended step, advance the model, compare.
  task automatic cyc(input string tag, input int kind, input logic mm, input logic [7:0] d,
                     input logic rdy, input logic en);
    int dv, t, r;
    bit pub;
    e = en; m = mm; din = d; result_ready = rdy; done = 1'b0;
    case (kind)
      K_A:    begin s0 = 1'b0; s1 = 1'($urandom); s2 = 1'($urandom); end
      K_B:    begin s0 = 1'b1; s1 = 1'b0; s2 = 1'($urandom); end
      K_C:    begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b0; end
      K_F:    begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b1; done = 1'b1; end
      K_ILL1: begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b1; end
      default: begin
        r = $urandom_range(0, 6);
        s0 = r[0]; s1 = r[1]; s2 = r[2]; done = 1'b1;
      end
    endcase
    dv  = int'($signed(d));
    pub = 0;
    if (en) begin
      case (kind)
        K_A: begin md_a = dv; md_acc = dv; md_ovf = 0; md_err = 0; md_stage = 1; end
        K_B, K_C: begin
          if (md_stage == kind) begin
            t = ((kind == K_B) ? md_a : md_acc) + (mm ? dv : -dv);
            if (t > 127 || t < -128) md_ovf = 1;
            md_acc   = wrap8(t);
            md_stage = kind + 1;
          end else md_err = 1;
        end
        K_F: begin
          if (md_stage == 3) begin
            md_stage = 0;
            if (!md_valid || rdy) begin md_res = md_acc; md_valid = 1; pub = 1; end
            else md_ovr = 1;
          end else md_err = 1;
        end
        default: md_err = 1;
      endcase
    end
    if (!pub && md_valid && rdy) md_valid = 0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse away from any clock edge; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int kind;
    logic en, rdy;
    rst = 1'b1; e = 1'b0; m = 1'b0; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; done = 1'b0;
    din = 8'd0; result_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 10 + 5 - 3 = 12
    cyc("s1a", K_A, 1'b0, 8'd10, 1'b0, 1'b1);
    cyc("s1b", K_B, 1'b1, 8'd5,  1'b0, 1'b1);
    cyc("s1c", K_C, 1'b0, 8'd3,  1'b0, 1'b1);
    cyc("s1f", K_F, 1'b0, 8'd0,  1'b0, 1'b1);
    check("s1_result", {24'd0, result}, 32'd12);

    // 10 - 20 + 4 = -6, accepted on the publishing cycle's successor
    cyc("s2a", K_A, 1'b0, 8'd10, 1'b1, 1'b1);
    cyc("s2b", K_B, 1'b0, 8'd20, 1'b0, 1'b1);
    cyc("s2c", K_C, 1'b1, 8'd4,  1'b0, 1'b1);
    cyc("s2f", K_F, 1'b0, 8'd0,  1'b1, 1'b1);
    check("s2_result", {24'd0, result}, 32'hFA);

    // 100 + 100 overflows; C with 0 keeps ovf; next A clears it
    cyc("s3a", K_A, 1'b0, 8'd100, 1'b1, 1'b1);
    cyc("s3b", K_B, 1'b1, 8'd100, 1'b0, 1'b1);
    check("s3_ovf", {31'd0, ovf}, 32'd1);
    cyc("s3c", K_C, 1'b0, 8'd0,   1'b0, 1'b1);
    cyc("s3f", K_F, 1'b0, 8'd0,   1'b0, 1'b1);
    check("s3_result", {24'd0, result}, 32'hC8);
    cyc("s3a2", K_A, 1'b0, 8'd1,  1'b1, 1'b1);

    // Out-of-order C, recovery via B, then e=0 hold
    cyc("s4a", K_A, 1'b0, 8'd7, 1'b0, 1'b1);
    cyc("s4c", K_C, 1'b1, 8'd1, 1'b0, 1'b1);
    cyc("s4b", K_B, 1'b1, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("s4hold", K_C, 1'b1, 8'd55, 1'b0, 1'b0);
    cyc("s4c2", K_C, 1'b1, 8'd0, 1'b0, 1'b1);
    cyc("s4f",  K_F, 1'b0, 8'd0, 1'b0, 1'b1);
    check("s4_result", {24'd0, result}, 32'd8);

    // Backpressure: drain, publish 12, drop 30 (overrun), publish 5 on F+ready
    cyc("bp_drain", K_A, 1'b0, 8'd10, 1'b1, 1'b1);
    cyc("bp1b", K_B, 1'b1, 8'd5, 1'b0, 1'b1);
    cyc("bp1c", K_C, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc("bp1f", K_F, 1'b0, 8'd0, 1'b0, 1'b1);
    cyc("bp2a", K_A, 1'b0, 8'd10, 1'b0, 1'b1);
    cyc("bp2b", K_B, 1'b1, 8'd10, 1'b0, 1'b1);
    cyc("bp2c", K_C, 1'b1, 8'd10, 1'b0, 1'b1);
    cyc("bp2f", K_F, 1'b0, 8'd0,  1'b0, 1'b1);
    check("bp2_result", {24'd0, result}, 32'd12);
    check("bp2_overrun", {31'd0, overrun}, 32'd1);
    cyc("bp3a", K_A, 1'b0, 8'd2, 1'b0, 1'b1);
    cyc("bp3b", K_B, 1'b1, 8'd2, 1'b0, 1'b1);
    cyc("bp3c", K_C, 1'b1, 8'd1, 1'b0, 1'b1);
    cyc("bp3f", K_F, 1'b0, 8'd0, 1'b1, 1'b1);
    check("bp3_result", {24'd0, result}, 32'd5);
    check("bp3_valid", {31'd0, result_valid}, 32'd1);

    // Reset between B and C, then C is out of order
    cyc("rsa", K_A, 1'b0, 8'd3, 1'b1, 1'b1);
    cyc("rsb", K_B, 1'b1, 8'd4, 1'b0, 1'b1);
    async_reset("rs_async");
    cyc("rsc", K_C, 1'b1, 8'd1, 1'b0, 1'b1);
    check("rs_seq_err", {31'd0, seq_err}, 32'd1);

    // Random traffic, biased toward the next legal step
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 80) kind = (md_stage == 3) ? K_F : md_stage;
      else kind = $urandom_range(0, 5);
      en  = ($urandom_range(0, 99) < 85);
      rdy = en ? 1'($urandom) : 1'b0;
      cyc("rand", kind, 1'($urandom), 8'($urandom), rdy, en);
      if ($urandom_range(0, 99) < 2) async_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
